// File: rtl/nand_op_sequencer_if.sv
// Host and flash-side signal bundle for the NAND operation sequencer.
// slave is the sequencer's view; master is the host / timing-FSM side.
interface nand_op_sequencer_if;
    // host request
    logic        op_req;
    logic [1:0]  op_code;
    logic [15:0] col_addr;
    logic [23:0] row_addr;
    // flash / timing FSM inputs
    logic        rb_n;
    logic        tfsm_done;
    logic [7:0]  status_in;
    // sequencer outputs
    logic        tfsm_start;
    logic [2:0]  tfsm_cmd;
    logic [7:0]  dout;
    logic        busy;
    logic        op_done;
    logic        op_err;
    logic [7:0]  status_q;

    modport slave (
        input  op_req, op_code, col_addr, row_addr, rb_n, tfsm_done, status_in,
        output tfsm_start, tfsm_cmd, dout, busy, op_done, op_err, status_q
    );

    modport master (
        output op_req, op_code, col_addr, row_addr, rb_n, tfsm_done, status_in,
        input  tfsm_start, tfsm_cmd, dout, busy, op_done, op_err, status_q
    );
endinterface

// File: rtl/nand_op_sequencer.sv
// NAND operation sequencer: walks a fixed per-op step table, issuing
// command/address/data steps to the timing FSM and waiting on R/B_n.
module nand_op_sequencer #(
    parameter logic [15:0] RB_TIMEOUT = 16'd50000,
    parameter int          ADDR_CYC   = 5
) (
    input  logic               CLK,
    input  logic               RES,
    nand_op_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_DONE, WAIT_RB, NEXT, COMPLETE
    } state_t;

    // XFER: any step handed to the timing FSM; READ1 also captures status;
    // WAITRB is handled locally; END marks one past the last step.
    typedef enum logic [1:0] {
        K_XFER, K_READ1, K_WAITRB, K_END
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] cmd;
        logic [7:0] data;
    } step_t;

    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_STATUS = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;

    localparam logic [2:0] C_CMD   = 3'b000;
    localparam logic [2:0] C_ADDR  = 3'b001;
    localparam logic [2:0] C_READ1 = 3'b010;
    localparam logic [2:0] C_RD2K  = 3'b101;
    localparam logic [2:0] C_WR2K  = 3'b111;

    // Address byte order on the bus: col low, col high, row low/mid/high.
    function automatic logic [7:0] addr_byte(input int k,
                                             input logic [15:0] col,
                                             input logic [23:0] row);
        logic [7:0] b;
        case (k)
            0:       b = col[7:0];
            1:       b = col[15:8];
            2:       b = row[7:0];
            3:       b = row[15:8];
            4:       b = row[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic step_t lookup(input logic [1:0]  op,
                                     input logic [3:0]  idx,
                                     input logic [15:0] col,
                                     input logic [23:0] row);
        step_t s;
        int    i;
        i = int'(idx);
        s = '{kind: K_XFER, cmd: C_CMD, data: 8'h00};
        case (op)
            OP_RESET: begin
                if (i == 0)      s.data = 8'hFF;
                else if (i == 1) s.kind = K_WAITRB;
                else             s.kind = K_END;
            end
            OP_STATUS: begin
                if (i == 0)      s.data = 8'h70;
                else if (i == 1) begin s.kind = K_READ1; s.cmd = C_READ1; end
                else             s.kind = K_END;
            end
            OP_READ: begin
                if (i == 0)                  s.data = 8'h00;
                else if (i <= ADDR_CYC)      begin s.cmd = C_ADDR; s.data = addr_byte(i - 1, col, row); end
                else if (i == ADDR_CYC + 1)  s.data = 8'h30;
                else if (i == ADDR_CYC + 2)  s.kind = K_WAITRB;
                else if (i == ADDR_CYC + 3)  s.cmd = C_RD2K;
                else                         s.kind = K_END;
            end
            default: begin
                if (i == 0)                  s.data = 8'h80;
                else if (i <= ADDR_CYC)      begin s.cmd = C_ADDR; s.data = addr_byte(i - 1, col, row); end
                else if (i == ADDR_CYC + 1)  s.cmd = C_WR2K;
                else if (i == ADDR_CYC + 2)  s.data = 8'h10;
                else if (i == ADDR_CYC + 3)  s.kind = K_WAITRB;
                else if (i == ADDR_CYC + 4)  s.data = 8'h70;
                else if (i == ADDR_CYC + 5)  begin s.kind = K_READ1; s.cmd = C_READ1; end
                else                         s.kind = K_END;
            end
        endcase
        return s;
    endfunction

    state_t      state;
    logic [3:0]  step_q;
    logic [1:0]  op_q;
    logic [15:0] col_q;
    logic [23:0] row_q;
    logic [15:0] rb_cnt;
    logic        rb_guard;
    logic        read1_q;
    logic        start_q;
    logic [2:0]  cmd_q;
    logic [7:0]  dout_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  stat_q;
    step_t       ent;

    // Step about to be entered: step 0 of the incoming request in IDLE,
    // otherwise the step after the current one.
    always_comb begin
        if (state == IDLE)
            ent = lookup(bus.op_code, 4'd0, bus.col_addr, bus.row_addr);
        else
            ent = lookup(op_q, step_q + 4'd1, col_q, row_q);
    end

    // Sequencer FSM with registered outputs; cmd/dout hold until the next
    // step is entered so they stay stable through the timing FSM's done.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state    <= IDLE;
            step_q   <= 4'd0;
            op_q     <= 2'b00;
            col_q    <= 16'h0000;
            row_q    <= 24'h000000;
            rb_cnt   <= 16'h0000;
            rb_guard <= 1'b0;
            read1_q  <= 1'b0;
            start_q  <= 1'b0;
            cmd_q    <= 3'b000;
            dout_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            stat_q   <= 8'h00;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op_req) begin
                        op_q   <= bus.op_code;
                        col_q  <= bus.col_addr;
                        row_q  <= bus.row_addr;
                        step_q <= 4'd0;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        if (ent.kind == K_WAITRB) begin
                            state    <= WAIT_RB;
                            rb_cnt   <= 16'h0000;
                            rb_guard <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            start_q <= 1'b1;
                            cmd_q   <= ent.cmd;
                            dout_q  <= ent.data;
                            read1_q <= (ent.kind == K_READ1);
                        end
                    end
                end
                ISSUE: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.tfsm_done) begin
                        if (read1_q) stat_q <= bus.status_in;
                        state <= NEXT;
                    end
                end
                WAIT_RB: begin
                    // first cycle ignores a ready rb_n: flash may not have
                    // dropped R/B_n yet after the command
                    rb_guard <= 1'b0;
                    if (!bus.rb_n) begin
                        rb_cnt <= rb_cnt + 16'd1;
                        if (rb_cnt == RB_TIMEOUT - 16'd1) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= COMPLETE;
                        end
                    end else if (!rb_guard) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (ent.kind == K_END) begin
                        done_q <= 1'b1;
                        if (op_q == 2'b11 && stat_q[0]) err_q <= 1'b1;
                        state <= COMPLETE;
                    end else begin
                        step_q <= step_q + 4'd1;
                        if (ent.kind == K_WAITRB) begin
                            state    <= WAIT_RB;
                            rb_cnt   <= 16'h0000;
                            rb_guard <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            start_q <= 1'b1;
                            cmd_q   <= ent.cmd;
                            dout_q  <= ent.data;
                            read1_q <= (ent.kind == K_READ1);
                        end
                    end
                end
                COMPLETE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tfsm_start = start_q;
    assign bus.tfsm_cmd   = cmd_q;
    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.op_done    = done_q;
    assign bus.op_err     = err_q;
    assign bus.status_q   = stat_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Bench for nand_op_sequencer: timing-FSM/flash model plus directed vectors.
module tb_nand_op_sequencer;

    localparam logic [15:0] TMO = 16'd300;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nand_op_sequencer_if bus();

    nand_op_sequencer #(.RB_TIMEOUT(TMO), .ADDR_CYC(5)) dut (
        .CLK (clk),
        .RES (res),
        .bus (bus)
    );

    logic model_done  = 1'b0;
    logic spur_done   = 1'b0;
    logic model_rb_n  = 1'b1;
    logic rb_force_lo = 1'b0;
    int   rb_low      = 0;

    assign bus.tfsm_done = model_done | spur_done;
    assign bus.rb_n      = model_rb_n & ~rb_force_lo;

    logic [2:0] log_cmd[$];
    logic [7:0] log_dout[$];
    int         log_cyc[$];
    int         done_cyc = 0;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Timing FSM model: done 5 cycles after start; busy-inducing commands
    // then pull rb_n low for rb_low cycles. Aborts on reset.
    logic [2:0] m_cmd;
    logic [7:0] m_dout;
    bit         m_ab;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!res && bus.tfsm_start) begin
                m_cmd  = bus.tfsm_cmd;
                m_dout = bus.dout;
                log_cmd.push_back(m_cmd);
                log_dout.push_back(m_dout);
                log_cyc.push_back(cyc);
                m_ab = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    if (res) m_ab = 1'b1;
                    if (m_ab) break;
                end
                if (!m_ab) begin
                    chk("cmd_stable", 80'({bus.tfsm_cmd, bus.dout}), 80'({m_cmd, m_dout}));
                    model_done = 1'b1;
                    done_cyc   = cyc;
                    @(posedge clk); #1;
                    model_done = 1'b0;
                    if (rb_low > 0 && m_cmd == 3'b000 &&
                        (m_dout == 8'hFF || m_dout == 8'h30 || m_dout == 8'h10)) begin
                        model_rb_n = 1'b0;
                        for (int k = 0; k < rb_low; k++) begin
                            @(posedge clk); #1;
                            if (res) break;
                        end
                        model_rb_n = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    task automatic clear_log();
        log_cmd.delete();
        log_dout.delete();
        log_cyc.delete();
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] col, input logic [23:0] row);
        int n = 0;
        while (bus.busy && n < 5000) begin @(posedge clk); #1; n++; end
        bus.op_code  = op;
        bus.col_addr = col;
        bus.row_addr = row;
        bus.op_req   = 1'b1;
        @(posedge clk); #1;
        bus.op_req   = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        while (!bus.op_done && n < 2000) begin @(posedge clk); #1; n++; end
        chk("done_seen", 80'(bus.op_done), 80'(1));
        at = cyc;
    endtask

    function automatic logic [29:0] pack_cmds();
        logic [29:0] p = '0;
        foreach (log_cmd[i]) p = {p[26:0], log_cmd[i]};
        return p;
    endfunction

    function automatic logic [79:0] pack_dout();
        logic [79:0] p = '0;
        foreach (log_dout[i]) p = {p[71:0], log_dout[i]};
        return p;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [15:0] col;
        logic [23:0] row;
        logic [7:0]  st;
        int          rbl;
        int          n;
        logic [29:0] cmds;
        logic [79:0] douts;
        logic [7:0]  exp_sq;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    int   at;
    int   n0;

    initial begin
        vecs[0] = '{2'b01, 16'h0000, 24'h000000, 8'hE0, 0, 2,
                    30'({3'o0, 3'o2}), 80'({8'h70, 8'h00}), 8'hE0, 1'b0};
        vecs[1] = '{2'b10, 16'h0012, 24'h034567, 8'h55, 100, 8,
                    30'({3'o0, 3'o1, 3'o1, 3'o1, 3'o1, 3'o1, 3'o0, 3'o5}),
                    80'({8'h00, 8'h12, 8'h00, 8'h67, 8'h45, 8'h03, 8'h30, 8'h00}), 8'hE0, 1'b0};
        vecs[2] = '{2'b11, 16'hABCD, 24'h123456, 8'h01, 20, 10,
                    {3'o0, 3'o1, 3'o1, 3'o1, 3'o1, 3'o1, 3'o7, 3'o0, 3'o0, 3'o2},
                    {8'h80, 8'hCD, 8'hAB, 8'h56, 8'h34, 8'h12, 8'h00, 8'h10, 8'h70, 8'h00}, 8'h01, 1'b1};
        vecs[3] = '{2'b11, 16'h0000, 24'h800001, 8'hFE, 5, 10,
                    {3'o0, 3'o1, 3'o1, 3'o1, 3'o1, 3'o1, 3'o7, 3'o0, 3'o0, 3'o2},
                    {8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'h10, 8'h70, 8'h00}, 8'hFE, 1'b0};
        vecs[4] = '{2'b00, 16'h0000, 24'h000000, 8'h77, 10, 1,
                    30'(3'o0), 80'(8'hFF), 8'hFE, 1'b0};
        vecs[5] = '{2'b01, 16'h0000, 24'h000000, 8'h3C, 0, 2,
                    30'({3'o0, 3'o2}), 80'({8'h70, 8'h00}), 8'h3C, 1'b0};

        bus.op_req    = 1'b0;
        bus.op_code   = 2'b00;
        bus.col_addr  = 16'h0000;
        bus.row_addr  = 24'h000000;
        bus.status_in = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 80'({bus.tfsm_start, bus.tfsm_cmd, bus.dout, bus.busy,
                                 bus.op_done, bus.op_err, bus.status_q}), 80'(0));
        #2 res = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // table-driven ops
        for (int v = 0; v < 6; v++) begin
            clear_log();
            rb_low        = vecs[v].rbl;
            bus.status_in = vecs[v].st;
            do_req(vecs[v].op, vecs[v].col, vecs[v].row);
            wait_done(at);
            chk($sformatf("v%0d_err", v), 80'(bus.op_err), 80'(vecs[v].exp_err));
            chk($sformatf("v%0d_status", v), 80'(bus.status_q), 80'(vecs[v].exp_sq));
            chk($sformatf("v%0d_busy_at_done", v), 80'(bus.busy), 80'(1));
            chk($sformatf("v%0d_nstart", v), 80'(log_cmd.size()), 80'(vecs[v].n));
            chk($sformatf("v%0d_cmds", v), 80'(pack_cmds()), 80'(vecs[v].cmds));
            chk($sformatf("v%0d_douts", v), pack_dout(), vecs[v].douts);
            if (vecs[v].op == 2'b10 && log_cyc.size() >= 8) begin
                for (int i = 1; i < 7; i++)
                    chk($sformatf("v%0d_gap%0d", v, i), 80'(log_cyc[i] - log_cyc[i-1]), 80'(7));
                chk($sformatf("v%0d_gap_rb", v), 80'(log_cyc[7] - log_cyc[6]), 80'(vecs[v].rbl + 8));
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", v), 80'({bus.op_done, bus.busy}), 80'(0));
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_err_hold", v), 80'(bus.op_err), 80'(vecs[v].exp_err));
        end

        // R/B_n already ready on entry: one guard cycle before moving on
        clear_log();
        rb_low = 0;
        do_req(2'b00, 16'h0000, 24'h000000);
        wait_done(at);
        chk("rb_guard_latency", 80'(at - done_cyc), 80'(5));
        chk("rb_guard_err", 80'(bus.op_err), 80'(0));

        // R/B_n stuck low: timeout
        rb_force_lo = 1'b1;
        clear_log();
        do_req(2'b00, 16'h0000, 24'h000000);
        wait_done(at);
        chk("tmo_cycles", 80'(at - (done_cyc + 2)), 80'(TMO));
        chk("tmo_err", 80'(bus.op_err), 80'(1));
        rb_force_lo = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // spurious done while idle
        clear_log();
        n0 = int'(bus.status_q);
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("spur_idle", 80'({bus.busy, bus.op_done, bus.tfsm_start}), 80'(0));
        chk("spur_nstart", 80'(log_cmd.size()), 80'(0));
        chk("spur_status", 80'(bus.status_q), 80'(n0));

        // op_req while busy is ignored
        bus.status_in = 8'h11;
        do_req(2'b01, 16'h0000, 24'h000000);
        @(posedge clk); #1;
        bus.op_code = 2'b10;
        bus.op_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.op_req  = 1'b0;
        wait_done(at);
        chk("busy_req_cmds", 80'(pack_cmds()), 80'({3'o0, 3'o2}));
        chk("busy_req_status", 80'(bus.status_q), 80'(8'h11));
        repeat (3) @(posedge clk);
        #1;
        chk("busy_req_idle", 80'(bus.busy), 80'(0));

        // reset during PAGE_READ address byte 3
        clear_log();
        rb_low = 100;
        do_req(2'b10, 16'h0012, 24'h034567);
        begin
            int n = 0;
            while (log_cmd.size() < 5 && n < 500) begin @(posedge clk); #1; n++; end
        end
        chk("reach_addr3", 80'(log_cmd.size() >= 5), 80'(1));
        #2 res = 1'b1;
        #1;
        chk("rst_async", 80'({bus.tfsm_start, bus.tfsm_cmd, bus.dout, bus.busy,
                             bus.op_done, bus.op_err, bus.status_q}), 80'(0));
        repeat (3) @(posedge clk);
        #3 res = 1'b0;
        n0 = log_cmd.size();
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_start", 80'(log_cmd.size()), 80'(n0));
        chk("rst_idle", 80'(bus.busy), 80'(0));
        clear_log();
        rb_low = 0;
        bus.status_in = 8'h5A;
        do_req(2'b01, 16'h0000, 24'h000000);
        wait_done(at);
        chk("post_rst_cmds", 80'(pack_cmds()), 80'({3'o0, 3'o2}));
        chk("post_rst_status", 80'(bus.status_q), 80'(8'h5A));
        chk("post_rst_err", 80'(bus.op_err), 80'(0));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
